// File: rtl/frame_signature_pkg.sv
// frame_signature_pkg: shared CRC constants and monitor state encoding.
package frame_signature_pkg;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/crc16_pixel_step.sv
// crc16_pixel_step: folds one whole pixel word into a CRC-16-CCITT, MSB first, combinationally.
module crc16_pixel_step
    import frame_signature_pkg::*;
#(
    parameter int PIXEL_BITS = 12
) (
    input  logic [15:0]           crc_in,
    input  logic [PIXEL_BITS-1:0] pixel_in,
    output logic [15:0]           crc_out
);
    logic [15:0] c;
    always_comb begin
        c = crc_in;
        for (int i = PIXEL_BITS - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ pixel_in[i]) ? CRC_POLY : 16'h0000);
        crc_out = c;
    end
endmodule

// File: rtl/frame_signature_monitor.sv
// frame_signature_monitor: per-frame CRC, pixel count and raster-order check of a video stream,
// with results latched at each falling v_sync.
module frame_signature_monitor
    import frame_signature_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int PIXEL_BITS  = 12,
    localparam int CNT_BITS   = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [WIDTH_BITS-1:0]  pixel_x_in,
    input  logic [HEIGHT_BITS-1:0] pixel_y_in,
    input  logic [PIXEL_BITS-1:0]  pixel_in,
    input  logic                   video_on_in,
    input  logic                   v_sync_in,
    input  logic                   compare_enable_in,
    input  logic [15:0]            expected_signature_in,
    output logic                   frame_done_out,
    output logic [15:0]            signature_out,
    output logic [CNT_BITS-1:0]    pixel_count_out,
    output logic                   order_error_out,
    output logic                   count_error_out,
    output logic                   match_out,
    output logic [15:0]            frame_count_out
);
    state_t                 state_q, state_d;
    logic                   v_sync_q, fall, accept, latch;
    logic [15:0]            crc_q, crc_step, crc_fin;
    logic [CNT_BITS-1:0]    cnt_q, cnt_fin;
    logic                   order_q, order_fin;
    logic [WIDTH_BITS-1:0]  x_q, x_nxt;
    logic [HEIGHT_BITS-1:0] y_q, y_nxt;
    logic                   x_last;

    crc16_pixel_step #(.PIXEL_BITS(PIXEL_BITS)) u_step (
        .crc_in  (crc_q),
        .pixel_in(pixel_in),
        .crc_out (crc_step)
    );

    // Final values fold in the pixel accepted on the fall cycle itself.
    always_comb begin
        fall      = v_sync_q & ~v_sync_in;
        accept    = (state_q == ACTIVE) & video_on_in;
        latch     = fall & (state_q == ACTIVE);
        state_d   = fall ? ACTIVE : state_q;
        crc_fin   = accept ? crc_step : crc_q;
        cnt_fin   = (accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        order_fin = order_q | (accept & ((pixel_x_in != x_q) | (pixel_y_in != y_q)));
        x_last    = pixel_x_in == WIDTH_BITS'(WIDTH - 1);
        x_nxt     = x_last ? '0 : pixel_x_in + 1'b1;
        y_nxt     = !x_last ? pixel_y_in :
                    (pixel_y_in == HEIGHT_BITS'(HEIGHT - 1)) ? '0 : pixel_y_in + 1'b1;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= IDLE;
            v_sync_q        <= 1'b1;
            crc_q           <= CRC_INIT;
            cnt_q           <= '0;
            order_q         <= 1'b0;
            x_q             <= '0;
            y_q             <= '0;
            frame_done_out  <= 1'b0;
            signature_out   <= '0;
            pixel_count_out <= '0;
            order_error_out <= 1'b0;
            count_error_out <= 1'b0;
            match_out       <= 1'b0;
            frame_count_out <= '0;
        end else begin
            v_sync_q       <= v_sync_in;
            state_q        <= state_d;
            frame_done_out <= latch;
            if (fall) begin
                crc_q   <= CRC_INIT;
                cnt_q   <= '0;
                order_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
            end else begin
                crc_q   <= crc_fin;
                cnt_q   <= cnt_fin;
                order_q <= order_fin;
                if (accept) begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                end
            end
            if (latch) begin
                signature_out   <= crc_fin;
                pixel_count_out <= cnt_fin;
                order_error_out <= order_fin;
                count_error_out <= cnt_fin != CNT_BITS'(WIDTH * HEIGHT);
                match_out       <= compare_enable_in & (crc_fin == expected_signature_in);
                frame_count_out <= frame_count_out + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_signature_monitor.sv
// tb_frame_signature_monitor: directed checks of reset, full-frame CRC, compare, order,
// fall-cycle pixel and frame counter wrap on three differently sized instances.
module tb_frame_signature_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b1, von = 1'b0, cmp = 1'b0;
    logic [9:0]  px = '0;
    logic [8:0]  py = '0;
    logic [11:0] pix = '0;
    logic [15:0] exp_sig = '0;
    int          checks = 0, failures = 0;

    logic        a_done, a_oe, a_ce, a_m;
    logic [15:0] a_sig, a_fc;
    logic [18:0] a_cnt;
    logic        b_done, b_oe, b_ce, b_m;
    logic [15:0] b_sig, b_fc;
    logic [3:0]  b_cnt;
    logic        c_done, c_oe, c_ce, c_m;
    logic [15:0] c_sig, c_fc;
    logic [0:0]  c_cnt;

    always #5 clk = ~clk;

    frame_signature_monitor dut_a (
        .clock_in(clk), .reset_in(rst), .pixel_x_in(px), .pixel_y_in(py), .pixel_in(pix),
        .video_on_in(von), .v_sync_in(vs), .compare_enable_in(cmp), .expected_signature_in(exp_sig),
        .frame_done_out(a_done), .signature_out(a_sig), .pixel_count_out(a_cnt),
        .order_error_out(a_oe), .count_error_out(a_ce), .match_out(a_m), .frame_count_out(a_fc)
    );

    frame_signature_monitor #(.WIDTH(4), .HEIGHT(2), .WIDTH_BITS(2), .HEIGHT_BITS(1)) dut_b (
        .clock_in(clk), .reset_in(rst), .pixel_x_in(px[1:0]), .pixel_y_in(py[0:0]), .pixel_in(pix),
        .video_on_in(von), .v_sync_in(vs), .compare_enable_in(cmp), .expected_signature_in(exp_sig),
        .frame_done_out(b_done), .signature_out(b_sig), .pixel_count_out(b_cnt),
        .order_error_out(b_oe), .count_error_out(b_ce), .match_out(b_m), .frame_count_out(b_fc)
    );

    frame_signature_monitor #(.WIDTH(1), .HEIGHT(1), .WIDTH_BITS(1), .HEIGHT_BITS(1)) dut_c (
        .clock_in(clk), .reset_in(rst), .pixel_x_in(px[0:0]), .pixel_y_in(py[0:0]), .pixel_in(pix),
        .video_on_in(von), .v_sync_in(vs), .compare_enable_in(cmp), .expected_signature_in(exp_sig),
        .frame_done_out(c_done), .signature_out(c_sig), .pixel_count_out(c_cnt),
        .order_error_out(c_oe), .count_error_out(c_ce), .match_out(c_m), .frame_count_out(c_fc)
    );

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] p);
        logic [15:0] r = c;
        for (int i = 11; i >= 0; i--) begin
            logic fb = r[15] ^ p[i];
            r = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input logic v, input logic on, input int x, input int y, input logic [11:0] p);
        vs = v; von = on; px = x[9:0]; py = y[8:0]; pix = p;
        @(posedge clk); #1;
    endtask

    logic [15:0] crc, z8;

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_outputs", {a_done, a_sig, a_cnt, a_oe, a_ce, a_m, a_fc}, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("first_fall_no_done", a_done, 0);
        cyc(1, 1, 0, 0, 12'h123);
        cyc(0, 0, 0, 0, 0);
        chk("f1_done", a_done, 1);
        chk("f1_count", a_cnt, 1);
        chk("f1_frames", a_fc, 1);
        chk("f1_sig", a_sig, crc_model(16'hFFFF, 12'h123));
        cyc(1, 1, 0, 0, 0);
        chk("done_one_cycle", a_done, 0);
        rst = 1'b1; #1;
        chk("midstream_reset", {a_done, a_sig, a_cnt, a_oe, a_ce, a_m, a_fc}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("post_reset_fall1", a_done, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("post_reset_fall2", a_done, 1);
        chk("post_reset_frames", a_fc, 1);

        crc = 16'hFFFF;
        for (int y = 0; y < 480; y++)
            for (int x = 0; x < 640; x++) begin
                logic [11:0] p = ((x < 320) == (y < 240)) ? 12'hFFF : 12'h000;
                crc = crc_model(crc, p);
                cyc(1, 1, x, y, p);
            end
        cyc(0, 0, 0, 0, 0);
        chk("cb_done", a_done, 1);
        chk("cb_count", a_cnt, 307200);
        chk("cb_count_err", a_ce, 0);
        chk("cb_order_err", a_oe, 0);
        chk("cb_sig", a_sig, crc);
        chk("cb_match_disabled", a_m, 0);

        z8 = 16'hFFFF;
        for (int i = 0; i < 8; i++) z8 = crc_model(z8, 12'h000);
        cmp = 1'b1;
        exp_sig = z8;
        for (int i = 0; i < 8; i++) cyc(1, 1, i % 4, i / 4, 0);
        cyc(0, 0, 0, 0, 0);
        chk("zero_match", b_m, 1);
        chk("zero_sig", b_sig, z8);
        chk("zero_count", b_cnt, 8);
        chk("zero_count_err", b_ce, 0);
        chk("zero_order_err", b_oe, 0);
        exp_sig = z8 ^ 16'h0001;
        for (int i = 0; i < 8; i++) cyc(1, 1, i % 4, i / 4, 0);
        cyc(0, 0, 0, 0, 0);
        chk("zero_mismatch", b_m, 0);

        for (int i = 0; i < 8; i++)
            if (i != 2) cyc(1, 1, i % 4, i / 4, 0);
        cyc(0, 0, 0, 0, 0);
        chk("skip_order_err", b_oe, 1);
        chk("skip_count", b_cnt, 7);
        chk("skip_count_err", b_ce, 1);
        chk("skip_frames", b_fc, 5);

        exp_sig = z8;
        for (int i = 0; i < 7; i++) cyc(1, 1, i % 4, i / 4, 0);
        cyc(0, 1, 3, 1, 0);
        chk("fallpix_count", b_cnt, 8);
        chk("fallpix_count_err", b_ce, 0);
        chk("fallpix_order_err", b_oe, 0);
        chk("fallpix_match", b_m, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("next_frame_done", b_done, 1);
        chk("next_frame_count", b_cnt, 0);
        chk("next_frame_count_err", b_ce, 1);

        rst = 1'b1;
        cyc(1, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        for (int f = 0; f < 65536; f++) begin
            cyc(1, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            if (f == 65534) chk("frames_ffff", c_fc, 16'hFFFF);
        end
        chk("frames_wrap", c_fc, 0);
        chk("wrap_done", c_done, 1);
        chk("wrap_count", c_cnt, 1);
        chk("wrap_count_err", c_ce, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
